// File: rtl/tree_acc_ctrl.sv
// Job sequencer/accumulator behind the 32-input tree adder: biases and sums
// NUM_PASS tree sums per job, then emits one saturated, optionally ReLU'd result.
module tree_acc_ctrl #(
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [PASS_W-1:0] num_pass_i,
    input  logic [31:0]       bias_i,
    input  logic              relu_en_i,
    output logic              busy_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       tree_sum_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  out_data_o,
    output logic              out_sat_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [PASS_W-1:0]        cnt_q;
    logic [PASS_W-1:0]        num_pass_q;
    logic                     relu_q;
    logic                     busy_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic [OUT_W-1:0]         out_data_q;
    logic                     out_sat_q;
    logic                     done_q;

    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  f_in;
    logic                     f_relu;
    logic [OUT_W-1:0]         out_data_d;
    logic                     out_sat_d;
    logic                     beat;
    logic                     last_beat;

    assign bias_ext  = {{(ACC_W-32){bias_i[31]}}, bias_i};
    assign acc_d     = acc_q + {{(ACC_W-32){tree_sum_i[31]}}, tree_sum_i};
    assign beat      = in_valid_i & in_ready_q;
    assign last_beat = beat && (cnt_q == num_pass_q - PASS_W'(1));

    // A zero-length job finalises the bias directly from IDLE, so the result
    // path takes the live bias/relu inputs there and the latched copies otherwise.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        out_data_d = f_in[OUT_W-1:0];
        out_sat_d  = 1'b0;
        f_in       = (state_q == ST_IDLE) ? bias_ext : acc_d;
        f_relu     = (state_q == ST_IDLE) ? relu_en_i : relu_q;
        out_data_d = f_in[OUT_W-1:0];
        if (f_relu && f_in[ACC_W-1]) begin
            out_data_d = '0;
        end else if (f_in > OUT_MAX) begin
            out_data_d = OUT_MAX[OUT_W-1:0];
            out_sat_d  = 1'b1;
        end else if (f_in < OUT_MIN) begin
            out_data_d = OUT_MIN[OUT_W-1:0];
            out_sat_d  = 1'b1;
        end
    end

    // NOTE: all state below updates with non-blocking assignments so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            num_pass_q  <= '0;
            relu_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        num_pass_q <= num_pass_i;
                        relu_q     <= relu_en_i;
                        acc_q      <= bias_ext;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        if (num_pass_i != '0) begin
                            state_q    <= ST_ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= ST_OUT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= out_data_d;
                            out_sat_q   <= out_sat_d;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + PASS_W'(1);
                        if (last_beat) begin
                            state_q     <= ST_OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= out_data_d;
                            out_sat_q   <= out_sat_d;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sat_o   = out_sat_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_tree_acc_ctrl.sv
// Directed self-checking bench for tree_acc_ctrl: hand-computed results for
// normal, saturating, ReLU, stalled, zero-length and reset-interrupted jobs.
module tb_tree_acc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_pass;
    logic [31:0] bias;
    logic        relu_en;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] tree_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        done;

    int total = 0;
    int bad   = 0;

    tree_acc_ctrl #(.ACC_W(40), .OUT_W(32), .PASS_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .num_pass_i  (num_pass),
        .bias_i      (bias),
        .relu_en_i   (relu_en),
        .busy_o      (busy),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .tree_sum_i  (tree_sum),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_sat_o   (out_sat),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] np, input logic [31:0] b, input logic r);
        start    = 1'b1;
        num_pass = np;
        bias     = b;
        relu_en  = r;
        step();
        start    = 1'b0;
    endtask

    task automatic beat(input logic [31:0] s);
        in_valid = 1'b1;
        tree_sum = s;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  {31'd0, busy},      32'd0);
        check({tag, "_rdy"},   {31'd0, in_ready},  32'd0);
        check({tag, "_ovld"},  {31'd0, out_valid}, 32'd0);
        check({tag, "_done"},  {31'd0, done},      32'd0);
        check({tag, "_data"},  out_data,           32'd0);
        check({tag, "_sat"},   {31'd0, out_sat},   32'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] d, input logic s);
        check({tag, "_ovld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_rdy"},  {31'd0, in_ready},  32'd0);
        check({tag, "_data"}, out_data,           d);
        check({tag, "_sat"},  {31'd0, out_sat},   {31'd0, s});
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_hs_ovld"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_hs_done"}, {31'd0, done},      32'd1);
        check({tag, "_hs_busy"}, {31'd0, busy},      32'd0);
        step();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_pass  = '0;
        bias      = '0;
        relu_en   = 1'b0;
        in_valid  = 1'b0;
        tree_sum  = '0;
        out_ready = 1'b0;
        step();
        step();
        check_idle("reset");
        rst_n = 1'b1;
        step();

        // 1: 5 + 10 - 20 + 7 = 2
        start_job(8'd3, 32'd5, 1'b0);
        check("t1_busy", {31'd0, busy},     32'd1);
        check("t1_rdy",  {31'd0, in_ready}, 32'd1);
        beat(32'd10);
        beat(-32'sd20);
        check("t1_no_early_ovld", {31'd0, out_valid}, 32'd0);
        beat(32'd7);
        check_result("t1", 32'd2, 1'b0);
        handshake("t1");

        // 2: positive and negative saturation
        start_job(8'd2, 32'h7FFF_FFFF, 1'b0);
        beat(32'h7FFF_FFFF);
        beat(32'h7FFF_FFFF);
        check_result("t2p", 32'h7FFF_FFFF, 1'b1);
        handshake("t2p");
        start_job(8'd2, 32'h8000_0000, 1'b0);
        beat(32'h8000_0000);
        beat(32'h8000_0000);
        check_result("t2n", 32'h8000_0000, 1'b1);
        handshake("t2n");

        // 3: ReLU clamps without flagging saturation
        start_job(8'd1, 32'd0, 1'b1);
        beat(-32'sd100);
        check_result("t3r", 32'd0, 1'b0);
        handshake("t3r");
        start_job(8'd1, 32'd0, 1'b0);
        beat(-32'sd100);
        check_result("t3n", 32'hFFFF_FF9C, 1'b0);
        handshake("t3n");

        // 4: gapped input (beats 1,2,4,8 + bias 3 = 18), stalled output,
        //    start pulses and in_valid while busy are ignored
        start_job(8'd4, 32'd3, 1'b0);
        in_valid = 1'b1; tree_sum = 32'd1;   step();
        in_valid = 1'b0; tree_sum = 32'd100; start = 1'b1; num_pass = 8'd1; step();
        start = 1'b0;
        check("t4_rdy_gap", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0; tree_sum = 32'd200; step();
        in_valid = 1'b1; tree_sum = 32'd2;   step();
        in_valid = 1'b1; tree_sum = 32'd4;   step();
        check("t4_no_early_ovld", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0; tree_sum = 32'd300; step();
        in_valid = 1'b1; tree_sum = 32'd8;   step();
        check_result("t4", 32'd18, 1'b0);
        tree_sum = 32'd1000;
        start    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_stall_ovld", {31'd0, out_valid}, 32'd1);
            check("t4_stall_data", out_data, 32'd18);
            check("t4_stall_done", {31'd0, done}, 32'd0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        handshake("t4");
        check("t4_not_queued", {31'd0, busy}, 32'd0);

        // 5: zero-length job emits the bias one cycle after start
        start_job(8'd0, -32'sd7, 1'b0);
        check("t5_busy", {31'd0, busy}, 32'd1);
        check_result("t5", 32'hFFFF_FFF9, 1'b0);
        handshake("t5");

        // 6: reset mid-job discards the partial accumulation
        start_job(8'd5, 32'd100, 1'b0);
        beat(32'd50);
        beat(32'd60);
        rst_n = 1'b0;
        step();
        check_idle("t6_rst");
        rst_n = 1'b1;
        step();
        check_idle("t6_post");
        start_job(8'd1, 32'd1, 1'b0);
        beat(32'd1);
        check_result("t6", 32'd2, 1'b0);
        handshake("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
